// File: rtl/wb_arbiter_if.sv
// Writeback bus: three producer ports (ALU, SFT, LD) in, one register-file write port out.
interface wb_arbiter_if #(
  parameter int W_DATA  = 32,
  parameter int W_RADDR = 4,
  parameter int W_CNT   = 16
);
  logic               alu_v_i, sft_v_i, ld_v_i;
  logic [W_RADDR-1:0] alu_r_i, sft_r_i, ld_r_i;
  logic [W_DATA-1:0]  alu_d_i, sft_d_i, ld_d_i;
  logic               alu_rdy_o, sft_rdy_o, ld_rdy_o;
  logic               wb_o;
  logic [15:0]        wb_r_o;
  logic [W_DATA-1:0]  wb_data_o;
  logic               stall_o;
  logic [W_CNT-1:0]   conflict_cnt_o;

  modport slave (
    input  alu_v_i, sft_v_i, ld_v_i,
    input  alu_r_i, sft_r_i, ld_r_i,
    input  alu_d_i, sft_d_i, ld_d_i,
    output alu_rdy_o, sft_rdy_o, ld_rdy_o,
    output wb_o, wb_r_o, wb_data_o, stall_o, conflict_cnt_o
  );

  modport master (
    output alu_v_i, sft_v_i, ld_v_i,
    output alu_r_i, sft_r_i, ld_r_i,
    output alu_d_i, sft_d_i, ld_d_i,
    input  alu_rdy_o, sft_rdy_o, ld_rdy_o,
    input  wb_o, wb_r_o, wb_data_o, stall_o, conflict_cnt_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: one holding slot per unit, one registered write per cycle.
// Latency 2 cycles (slot + output register); a port is ready when its slot is empty or being granted.
module wb_arbiter #(
  parameter int W_DATA  = 32,
  parameter int W_RADDR = 4,
  parameter int W_CNT   = 16
) (
  input  logic           clk,
  input  logic           rst,
  wb_arbiter_if.slave    bus
);

  // Port index 0 = ALU, 1 = SFT, 2 = LD
  logic [2:0]         in_v;
  logic [W_RADDR-1:0] in_r [3];
  logic [W_DATA-1:0]  in_d [3];
  logic [2:0]         rdy;
  logic [2:0]         accept;

  logic [2:0]         slot_v_q, slot_v_d;
  logic [W_RADDR-1:0] slot_r_q [3];
  logic [W_RADDR-1:0] slot_r_d [3];
  logic [W_DATA-1:0]  slot_d_q [3];
  logic [W_DATA-1:0]  slot_d_d [3];
  logic [1:0]         ptr_q, ptr_d;
  logic               wb_q, wb_d;
  logic [15:0]        wb_r_q, wb_r_d;
  logic [W_DATA-1:0]  wb_data_q, wb_data_d;
  logic [W_CNT-1:0]   cnt_q, cnt_d;

  logic               gnt_vld;
  logic [1:0]         gnt_idx;
  logic [2:0]         gnt_oh;
  logic [1:0]         order [3];
  logic               contend;

  assign in_v    = {bus.ld_v_i, bus.sft_v_i, bus.alu_v_i};
  assign in_r[0] = bus.alu_r_i;
  assign in_r[1] = bus.sft_r_i;
  assign in_r[2] = bus.ld_r_i;
  assign in_d[0] = bus.alu_d_i;
  assign in_d[1] = bus.sft_d_i;
  assign in_d[2] = bus.ld_d_i;

  // Search order begins at the port after the last one granted
  always_comb begin
    order   = '{2'd0, 2'd1, 2'd2};
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    case (ptr_q)
      2'd0:    order = '{2'd1, 2'd2, 2'd0};
      2'd1:    order = '{2'd2, 2'd0, 2'd1};
      default: order = '{2'd0, 2'd1, 2'd2};
    endcase
    for (int k = 0; k < 3; k++) begin
      if (!gnt_vld && slot_v_q[order[k]]) begin
        gnt_vld = 1'b1;
        gnt_idx = order[k];
      end
    end
  end

  assign gnt_oh  = gnt_vld ? (3'b001 << gnt_idx) : 3'b000;
  assign rdy     = {3{rst}} | ~slot_v_q | gnt_oh;
  assign accept  = in_v & rdy;
  assign contend = (slot_v_q[0] & slot_v_q[1]) | (slot_v_q[0] & slot_v_q[2]) |
                   (slot_v_q[1] & slot_v_q[2]);

  always_comb begin
    slot_v_d  = (slot_v_q & ~gnt_oh) | accept;
    slot_r_d  = slot_r_q;
    slot_d_d  = slot_d_q;
    ptr_d     = ptr_q;
    wb_d      = 1'b0;
    wb_r_d    = '0;
    wb_data_d = wb_data_q;
    cnt_d     = cnt_q;
    for (int p = 0; p < 3; p++) begin
      if (accept[p]) begin
        slot_r_d[p] = in_r[p];
        slot_d_d[p] = in_d[p];
      end
    end
    if (gnt_vld) begin
      ptr_d     = gnt_idx;
      wb_d      = 1'b1;
      wb_r_d    = 16'(1) << slot_r_q[gnt_idx];
      wb_data_d = slot_d_q[gnt_idx];
    end
    if (contend && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v_q  <= '0;
      ptr_q     <= 2'd2;
      wb_q      <= 1'b0;
      wb_r_q    <= '0;
      wb_data_q <= '0;
      cnt_q     <= '0;
      for (int p = 0; p < 3; p++) begin
        slot_r_q[p] <= '0;
        slot_d_q[p] <= '0;
      end
    end else begin
      slot_v_q  <= slot_v_d;
      ptr_q     <= ptr_d;
      wb_q      <= wb_d;
      wb_r_q    <= wb_r_d;
      wb_data_q <= wb_data_d;
      cnt_q     <= cnt_d;
      for (int p = 0; p < 3; p++) begin
        slot_r_q[p] <= slot_r_d[p];
        slot_d_q[p] <= slot_d_d[p];
      end
    end
  end

  assign bus.alu_rdy_o      = rdy[0];
  assign bus.sft_rdy_o      = rdy[1];
  assign bus.ld_rdy_o       = rdy[2];
  assign bus.stall_o        = ~rst & (|(slot_v_q & ~gnt_oh));
  assign bus.wb_o           = wb_q;
  assign bus.wb_r_o         = wb_r_q;
  assign bus.wb_data_o      = wb_data_q;
  assign bus.conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a per-cycle behavioural model.
module tb_wb_arbiter;
  localparam int W_DATA  = 32;
  localparam int W_RADDR = 4;
  localparam int W_CNT   = 4;
  localparam int CNT_MAX = (1 << W_CNT) - 1;

  logic clk;
  logic rst;

  wb_arbiter_if #(.W_DATA(W_DATA), .W_RADDR(W_RADDR), .W_CNT(W_CNT)) bus ();

  wb_arbiter #(.W_DATA(W_DATA), .W_RADDR(W_RADDR), .W_CNT(W_CNT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_err;

  // Model state: pending result per unit, last winner, expected write port
  logic        m_v [3];
  logic [3:0]  m_r [3];
  logic [31:0] m_d [3];
  int          m_last;
  logic        m_wb;
  logic [15:0] m_wbr;
  logic [31:0] m_wbd;
  int          m_cnt;

  logic        s_v [3];
  logic [3:0]  s_r [3];
  logic [31:0] s_d [3];

  int          wb_seen;
  int          stall_seen;
  logic [15:0] wbq [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      m_v[p] = 1'b0;
      m_r[p] = '0;
      m_d[p] = '0;
    end
    m_last = 2;
    m_wb   = 1'b0;
    m_wbr  = '0;
    m_wbd  = '0;
    m_cnt  = 0;
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 3; p++) begin
      s_v[p] = 1'b0;
      s_r[p] = 4'($urandom);
      s_d[p] = $urandom;
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check ready/stall, advance model
  task automatic step(input logic r);
    int   g;
    int   nv;
    logic e_rdy [3];
    logic e_stall;
    logic g_rdy [3];
    @(negedge clk);
    chk("wb_o", 64'(bus.wb_o), 64'(m_wb));
    chk("wb_r_o", 64'(bus.wb_r_o), 64'(m_wbr));
    chk("wb_data_o", 64'(bus.wb_data_o), 64'(m_wbd));
    chk("conflict_cnt_o", 64'(bus.conflict_cnt_o), 64'(m_cnt));
    if (bus.wb_o === 1'b1) begin
      wb_seen++;
      wbq.push_back(bus.wb_r_o);
    end
    rst         = r;
    bus.alu_v_i = s_v[0]; bus.alu_r_i = s_r[0]; bus.alu_d_i = s_d[0];
    bus.sft_v_i = s_v[1]; bus.sft_r_i = s_r[1]; bus.sft_d_i = s_d[1];
    bus.ld_v_i  = s_v[2]; bus.ld_r_i  = s_r[2]; bus.ld_d_i  = s_d[2];
    #1;
    g  = -1;
    nv = 0;
    for (int k = 1; k <= 3; k++) begin
      if (m_v[(m_last + k) % 3] && g < 0) g = (m_last + k) % 3;
    end
    for (int p = 0; p < 3; p++) if (m_v[p]) nv++;
    e_stall = 1'b0;
    for (int p = 0; p < 3; p++) begin
      e_rdy[p] = r || !m_v[p] || (g == p);
      if (!r && m_v[p] && g != p) e_stall = 1'b1;
    end
    g_rdy[0] = bus.alu_rdy_o;
    g_rdy[1] = bus.sft_rdy_o;
    g_rdy[2] = bus.ld_rdy_o;
    chk("alu_rdy_o", 64'(g_rdy[0]), 64'(e_rdy[0]));
    chk("sft_rdy_o", 64'(g_rdy[1]), 64'(e_rdy[1]));
    chk("ld_rdy_o", 64'(g_rdy[2]), 64'(e_rdy[2]));
    chk("stall_o", 64'(bus.stall_o), 64'(e_stall));
    if (bus.stall_o === 1'b1) stall_seen++;
    if (r) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        m_wb   = 1'b1;
        m_wbr  = 16'(1) << m_r[g];
        m_wbd  = m_d[g];
        m_last = g;
        m_v[g] = 1'b0;
      end else begin
        m_wb  = 1'b0;
        m_wbr = '0;
      end
      if (nv >= 2 && m_cnt < CNT_MAX) m_cnt++;
      for (int p = 0; p < 3; p++) begin
        if (s_v[p] && e_rdy[p]) begin
          m_v[p] = 1'b1;
          m_r[p] = s_r[p];
          m_d[p] = s_d[p];
        end
      end
    end
  endtask

  initial begin
    int seen0;
    n_chk = 0; n_err = 0; wb_seen = 0; stall_seen = 0;
    rst = 1'b1;
    idle_inputs();
    bus.alu_v_i = 1'b0; bus.sft_v_i = 1'b0; bus.ld_v_i = 1'b0;
    bus.alu_r_i = '0; bus.sft_r_i = '0; bus.ld_r_i = '0;
    bus.alu_d_i = '0; bus.sft_d_i = '0; bus.ld_d_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    step(1'b1);

    // Single write to r5
    idle_inputs();
    s_v[0] = 1'b1; s_r[0] = 4'd5; s_d[0] = 32'h1234;
    step(1'b0);
    idle_inputs();
    step(1'b0);
    step(1'b0);
    chk("t1_wb", 64'(bus.wb_o), 64'd1);
    chk("t1_wb_r", 64'(bus.wb_r_o), 64'h0020);
    chk("t1_wb_data", 64'(bus.wb_data_o), 64'h1234);
    step(1'b0);
    chk("t1_wb_once", 64'(bus.wb_o), 64'd0);

    // Three-way contention right after reset
    step(1'b1);
    s_v[0] = 1'b1; s_r[0] = 4'd1;
    s_v[1] = 1'b1; s_r[1] = 4'd2;
    s_v[2] = 1'b1; s_r[2] = 4'd3;
    stall_seen = 0;
    wbq.delete();
    step(1'b0);
    idle_inputs();
    repeat (5) step(1'b0);
    chk("t2_cnt", 64'(bus.conflict_cnt_o), 64'd2);
    chk("t2_stall_cycles", 64'(stall_seen), 64'd2);
    chk("t2_wb_count", 64'(wbq.size()), 64'd3);
    if (wbq.size() == 3) begin
      chk("t2_order0", 64'(wbq[0]), 64'h0002);
      chk("t2_order1", 64'(wbq[1]), 64'h0004);
      chk("t2_order2", 64'(wbq[2]), 64'h0008);
    end

    // ALU and LD always valid
    step(1'b1);
    for (int i = 0; i < 16; i++) begin
      idle_inputs();
      s_v[0] = 1'b1;
      s_v[2] = 1'b1;
      step(1'b0);
    end
    idle_inputs();
    repeat (4) step(1'b0);

    // SFT streaming with incrementing data
    step(1'b1);
    seen0 = wb_seen;
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      s_v[1] = 1'b1;
      s_d[1] = 32'(i);
      step(1'b0);
    end
    idle_inputs();
    repeat (3) step(1'b0);
    chk("t4_stream_wbs", 64'(wb_seen - seen0), 64'd12);

    // Reset with two results pending
    s_v[0] = 1'b1; s_v[1] = 1'b1;
    step(1'b0);
    idle_inputs();
    step(1'b1);
    seen0 = wb_seen;
    repeat (4) step(1'b0);
    chk("t5_no_wb", 64'(wb_seen - seen0), 64'd0);
    chk("t5_cnt", 64'(bus.conflict_cnt_o), 64'd0);

    // Counter saturation
    for (int i = 0; i < (1 << W_CNT) + 8; i++) begin
      idle_inputs();
      for (int p = 0; p < 3; p++) s_v[p] = 1'b1;
      step(1'b0);
    end
    idle_inputs();
    repeat (4) step(1'b0);
    chk("t6_saturate", 64'(bus.conflict_cnt_o), 64'hF);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      for (int p = 0; p < 3; p++) s_v[p] = ($urandom_range(0, 99) < 55);
      step($urandom_range(0, 59) == 0);
    end
    idle_inputs();
    repeat (4) step(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter W_DATA, default 32, writeback data width.
REQ-002 SHALL have parameter W_RADDR, default 4, register address width (16 registers).
REQ-003 SHALL have parameter W_CNT, default 16, conflict counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have ports alu_v_i, sft_v_i, ld_v_i  input  1 each  result valid from ALU, shift/logic and load units.
REQ-007 SHALL have ports alu_r_i, sft_r_i, ld_r_i  input  W_RADDR each  destination register.
REQ-008 SHALL have ports alu_d_i, sft_d_i, ld_d_i  input  W_DATA each  result data.
REQ-009 SHALL have ports alu_rdy_o, sft_rdy_o, ld_rdy_o  output  1 each  port can accept a result this cycle.
REQ-010 SHALL have port wb_o  output  1  register-file write enable.
REQ-011 SHALL have port wb_r_o  output  16  one-hot destination register select.
REQ-012 SHALL have port wb_data_o  output  W_DATA  write data.
REQ-013 SHALL have port stall_o  output  1  any holding slot occupied and not granted this cycle.
REQ-014 SHALL have port conflict_cnt_o  output  W_CNT  saturating count of cycles with >=2 contenders.

Function
REQ-015 SHALL hold one slot per port (valid, register, data); result accepted when v_i and rdy_o are both 1 on a clock edge.
REQ-016 SHALL drive rdy_o = ~slot_valid | slot_granted_this_cycle (combinational, no dependence on v_i).
REQ-017 SHALL, each cycle, select among valid slots by round-robin, order ALU -> SFT -> LD, starting after the last granted port.
REQ-018 SHALL update the round-robin pointer only on a grant; with no grant the pointer holds.
REQ-019 SHALL register the winner: on the edge after grant, wb_o=1, wb_r_o=one-hot(reg), wb_data_o=data; latency from acceptance to wb_o is 2 cycles minimum (1 slot + 1 output).
REQ-020 SHALL drive wb_o=0, wb_r_o=0 and hold wb_data_o at its prior value in any cycle following no grant.
REQ-021 SHALL clear a granted slot and, if v_i is asserted in the same cycle, load it with the new result (full throughput per port when uncontended).
REQ-022 SHALL grant at most one slot per cycle; a sole valid slot is granted in the cycle it becomes valid.
REQ-023 SHALL increment conflict_cnt_o once per cycle in which >=2 slots are valid, saturating at all-ones.
REQ-024 SHALL guarantee bounded wait: a valid slot is granted within 3 cycles of becoming valid.
REQ-025 SHALL NOT order results to the same destination across ports; the ID register reservation prevents two pending writes to one register.
REQ-026 SHALL ignore r_i/d_i whenever v_i=0 or rdy_o=0.

Reset
REQ-027 SHALL, while rst=1 at an edge, clear all slots, set pointer to ALU-first, clear wb_o, wb_r_o, wb_data_o, conflict_cnt_o.
REQ-028 SHALL, during reset, drive all rdy_o=1 and stall_o=0; results presented during reset are dropped.
REQ-029 SHALL, on reset mid-operation, discard pending slots and any scheduled writeback (wb_o=0 the following cycle).

Verification
REQ-030 SHALL cover single write: alu_v_i=1, alu_r_i=5, alu_d_i=0x1234 for 1 cycle -> 2 cycles later wb_o=1, wb_r_o=0x0020, wb_data_o=0x1234 for exactly 1 cycle.
REQ-031 SHALL cover three-way contention: all ports valid same cycle (r=1,2,3) after reset -> writebacks r=1,2,3 on consecutive cycles; conflict_cnt_o=2; stall_o=1 for 2 cycles.
REQ-032 SHALL cover back-pressure: ALU and LD held valid continuously -> wb alternates ALU/LD; alu_rdy_o=1 only in ALU-grant cycles; no result lost or duplicated.
REQ-033 SHALL cover streaming: sft_v_i=1 every cycle with incrementing data, others idle -> wb_o=1 every cycle, data in order, sft_rdy_o constantly 1.
REQ-034 SHALL cover mid-operation reset: two slots pending, rst=1 for 1 cycle -> no wb_o afterward, conflict_cnt_o=0, all rdy_o=1.
REQ-035 SHALL cover saturation: force >=2 contenders for 2^W_CNT+5 cycles (W_CNT=4 build) -> conflict_cnt_o holds 0xF.
